// File: rtl/one_hot_slot_scheduler_pkg.sv
// Shared types and helpers for the one-hot round-robin slot scheduler.
package one_hot_slot_scheduler_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  // Widest pointer the index encoder accepts.
  localparam int unsigned ONEHOT_MAX = 32;

  // Counter width able to hold 0..slot_len.
  function automatic int unsigned cnt_width(input int unsigned slot_len);
    return $clog2(slot_len + 1);
  endfunction

  // One-hot to binary: OR together the indices of set bits.
  function automatic int unsigned onehot_to_index(input logic [ONEHOT_MAX-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ONEHOT_MAX; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/one_hot_slot_scheduler_slot_ring.sv
// N-bit one-hot ring register; rotates one position toward the MSB per enabled edge.
module one_hot_slot_scheduler_slot_ring #(
  parameter int N = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rot,
  output logic [N-1:0] o_slot
);

  logic [N-1:0] slot_q, slot_d;

  // Next pointer: rotate left with wrap of bit N-1 into bit 0.
  always_comb begin
    slot_d = slot_q;
    if (i_rot) slot_d = {slot_q[N-2:0], slot_q[N-1]};
  end

  // Pointer register; reset points at requester 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) slot_q <= {{(N-1){1'b0}}, 1'b1};
    else       slot_q <= slot_d;
  end

  assign o_slot = slot_q;

endmodule

// File: rtl/one_hot_slot_scheduler.sv
// Round-robin slot scheduler: a rotating one-hot pointer grants one requester
// at a time for at most SLOT_LEN cycles.
//
// state | meaning
// SCAN  | no owner; pointer tests one requester per enabled cycle
// GRANT | pointer parked on owner; counting slot cycles until exit
module one_hot_slot_scheduler
  import one_hot_slot_scheduler_pkg::*;
#(
  parameter int N        = 5,
  parameter int SLOT_LEN = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [N-1:0]         i_req,
  input  logic                 i_release,
  output logic [N-1:0]         o_grant,
  output logic [N-1:0]         o_slot,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int OW = $clog2(N);
  localparam int CW = cnt_width(SLOT_LEN);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  slot;
  logic          rot;
  logic          hit;
  logic          owner_req;
  logic          last_cycle;

  one_hot_slot_scheduler_slot_ring #(.N(N)) u_slot_ring (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rot  (rot),
    .o_slot (slot)
  );

  assign hit        = i_en && (|(i_req & slot));
  assign owner_req  = |(i_req & grant_q);
  assign last_cycle = (cnt_q == CW'(SLOT_LEN - 1));

  // Next-state, grant capture and pointer rotation; any exit rotates past the owner.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    rot       = 1'b0;
    case (state_q)
      SCAN: begin
        if (hit) begin
          state_d = GRANT;
          grant_d = slot;
          owner_d = OW'(onehot_to_index(ONEHOT_MAX'(slot)));
          cnt_d   = '0;
        end else if (i_en) begin
          rot = 1'b1;
        end
      end
      GRANT: begin
        if (i_release || !owner_req || last_cycle) begin
          state_d   = SCAN;
          grant_d   = '0;
          owner_d   = '0;
          cnt_d     = '0;
          rot       = 1'b1;
          timeout_d = !i_release && owner_req;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        grant_d = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_slot    = slot;
  assign o_owner   = owner_q;
  assign o_busy    = |grant_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_one_hot_slot_scheduler.sv
// Bench for one_hot_slot_scheduler: integer-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_one_hot_slot_scheduler;

  localparam int N        = 5;
  localparam int SLOT_LEN = 4;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_en = 1'b0;
  logic [N-1:0] i_req = '0;
  logic         i_release = 1'b0;
  logic [N-1:0] o_grant;
  logic [N-1:0] o_slot;
  logic [2:0]   o_owner;
  logic         o_busy;
  logic         o_timeout;

  one_hot_slot_scheduler #(.N(N), .SLOT_LEN(SLOT_LEN)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_req     (i_req),
    .i_release (i_release),
    .o_grant   (o_grant),
    .o_slot    (o_slot),
    .o_owner   (o_owner),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pointer position, owner (-1 idle), cycles granted so far, timeout flag.
  int m_ptr   = 0;
  int m_owner = -1;
  int m_len   = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_len = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [N-1:0] req, input logic rel);
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (en && req[m_ptr]) begin
        m_owner = m_ptr;
        m_len   = 1;
      end else if (en) begin
        m_ptr = (m_ptr + 1) % N;
      end
    end else begin
      if (rel || !req[m_owner]) begin
        m_owner = -1;
        m_ptr   = (m_ptr + 1) % N;
      end else if (m_len == SLOT_LEN) begin
        m_owner = -1;
        m_ptr   = (m_ptr + 1) % N;
        m_to    = 1'b1;
      end else begin
        m_len++;
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("cyc_grant", 32'(o_grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("cyc_slot", 32'(o_slot), 32'd1 << m_ptr);
      check("cyc_owner", 32'(o_owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check("cyc_busy", 32'(o_busy), 32'(m_owner >= 0));
      check("cyc_timeout", 32'(o_timeout), 32'(m_to));
    end
  end

  task automatic step(input logic en, input logic [N-1:0] req, input logic rel);
    i_en = en; i_req = req; i_release = rel;
    @(posedge i_clk);
    model_step(en, req, rel);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_en = 1'b0; i_req = '0; i_release = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  initial begin
    // Single requester on bit 3 with release in the 2nd grant cycle.
    do_reset();
    check("rst_slot", 32'(o_slot), 32'h01);
    check("rst_grant", 32'(o_grant), 32'h00);
    repeat (3) step(1'b1, 5'b01000, 1'b0);
    check("single_prehit_slot", 32'(o_slot), 32'h08);
    check("single_prehit_grant", 32'(o_grant), 32'h00);
    step(1'b1, 5'b01000, 1'b0);
    check("single_grant", 32'(o_grant), 32'h08);
    check("single_owner", 32'(o_owner), 32'd3);
    step(1'b1, 5'b01000, 1'b0);
    check("single_grant_c2", 32'(o_grant), 32'h08);
    step(1'b1, 5'b01000, 1'b1);
    check("single_released", 32'(o_grant), 32'h00);
    check("single_no_timeout", 32'(o_timeout), 32'd0);
    check("single_slot_after", 32'(o_slot), 32'h10);

    // Timeout on bit 0, then re-grant only after the pointer wraps.
    do_reset();
    step(1'b1, 5'b00001, 1'b0);
    check("to_grant", 32'(o_grant), 32'h01);
    repeat (3) step(1'b1, 5'b00001, 1'b0);
    check("to_grant_c4", 32'(o_grant), 32'h01);
    check("to_no_pulse_yet", 32'(o_timeout), 32'd0);
    step(1'b1, 5'b00001, 1'b0);
    check("to_ended", 32'(o_grant), 32'h00);
    check("to_pulse", 32'(o_timeout), 32'd1);
    step(1'b1, 5'b00001, 1'b0);
    check("to_pulse_one_cycle", 32'(o_timeout), 32'd0);
    repeat (3) step(1'b1, 5'b00001, 1'b0);
    check("to_wrap_idle", 32'(o_grant), 32'h00);
    check("to_wrap_slot", 32'(o_slot), 32'h01);
    step(1'b1, 5'b00001, 1'b0);
    check("to_regrant", 32'(o_grant), 32'h01);

    // Fairness with all requesting: 0,1,2,3,4,0 each for SLOT_LEN cycles.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 5'b11111, 1'b0);
      check("fair_owner", 32'(o_owner), 32'(k % N));
      check("fair_grant", 32'(o_grant), 32'd1 << (k % N));
      repeat (3) step(1'b1, 5'b11111, 1'b0);
      check("fair_hold", 32'(o_grant), 32'd1 << (k % N));
      step(1'b1, 5'b11111, 1'b0);
      check("fair_idle", 32'(o_grant), 32'h00);
      check("fair_timeout", 32'(o_timeout), 32'd1);
    end

    // Release in the last slot cycle wins over timeout.
    do_reset();
    repeat (4) step(1'b1, 5'b00001, 1'b0);
    step(1'b1, 5'b00001, 1'b1);
    check("coll_ended", 32'(o_grant), 32'h00);
    check("coll_no_timeout", 32'(o_timeout), 32'd0);

    // Enable low during a grant, then in SCAN, then request drop.
    do_reset();
    repeat (3) step(1'b1, 5'b00100, 1'b0);
    check("en_grant", 32'(o_grant), 32'h04);
    repeat (3) step(1'b0, 5'b00100, 1'b0);
    check("en_off_holds", 32'(o_grant), 32'h04);
    step(1'b0, 5'b00100, 1'b0);
    check("en_off_timeout", 32'(o_timeout), 32'd1);
    check("en_off_slot", 32'(o_slot), 32'h08);
    repeat (3) step(1'b0, 5'b01000, 1'b0);
    check("scan_frozen_slot", 32'(o_slot), 32'h08);
    check("scan_frozen_grant", 32'(o_grant), 32'h00);
    step(1'b1, 5'b01000, 1'b0);
    check("en_on_grant", 32'(o_grant), 32'h08);
    step(1'b1, 5'b01000, 1'b0);
    step(1'b1, 5'b00000, 1'b0);
    check("drop_ended", 32'(o_grant), 32'h00);
    check("drop_no_timeout", 32'(o_timeout), 32'd0);

    // Asynchronous reset in the middle of a grant to bit 2.
    do_reset();
    repeat (3) step(1'b1, 5'b00100, 1'b0);
    check("arst_pre_grant", 32'(o_grant), 32'h04);
    i_rst = 1'b1;
    #1;
    check("arst_grant", 32'(o_grant), 32'h00);
    check("arst_slot", 32'(o_slot), 32'h01);
    check("arst_busy", 32'(o_busy), 32'd0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    step(1'b1, 5'b00001, 1'b0);
    check("arst_first_scan", 32'(o_grant), 32'h01);

    @(negedge i_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
